lipsi_fetch: RTL

Instruction fetch sequencer for the LIPSI processor. It is the consumer side of the program counter: it reads the current PC, issues synchronous instruction-memory reads, and drives the PC's load/increment controls. It assembles one- and two-byte instructions and hands them to the execute stage over a valid/ready handshake. It also accepts branch redirects from execute.

---
 rtl/lipsi_fetch.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/lipsi_fetch.sv
// -----------------------------------------------------------------------------
// lipsi_fetch -- instruction fetch sequencer for the LIPSI processor.
//
// Reads the current program counter, issues synchronous instruction-memory
// reads, steers the PC block (load / increment), assembles one- or two-byte
// instructions and presents them to execute over a valid/ready handshake.
// Branch redirects from execute override any fetch in progress.
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous, active-high
//   pc_value         current PC from the PC block
//   pc_load          load PC with pc_load_value (combinational)
//   pc_inc           increment PC (combinational)
//   pc_load_value    PC load value (combinational)
//   mem_rd_en        instruction-memory read strobe (combinational)
//   mem_rd_addr      read address, data returns the following cycle
//   mem_rd_data      read data, valid the cycle after mem_rd_en
//   redirect         branch taken, one-cycle pulse from execute
//   redirect_target  branch target address
//   instr_valid      instruction available (registered)
//   instr_ready      execute accepts the instruction
//   instr_opcode     first instruction byte (registered)
//   instr_operand    second byte, 0 for one-byte instructions (registered)
//   instr_pc         address of the opcode byte (registered)
//   halted           fetch stopped (registered; tied low without FETCH_HALT_EN)
//
// Build option:
//   FETCH_HALT_EN    when defined, accepting opcode 0xFF parks the sequencer
//                    in HALT until reset and raises halted.
// -----------------------------------------------------------------------------
module lipsi_fetch (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc_value,
    output logic       pc_load,
    output logic       pc_inc,
    output logic [7:0] pc_load_value,
    output logic       mem_rd_en,
    output logic [7:0] mem_rd_addr,
    input  logic [7:0] mem_rd_data,
    input  logic       redirect,
    input  logic [7:0] redirect_target,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_operand,
    output logic [7:0] instr_pc,
    output logic       halted
);

`ifdef FETCH_HALT_EN
    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,
        OP_DATA  = 3'd1,
        IMM_DATA = 3'd2,
        ISSUE    = 3'd3,
        HALT     = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        OP_DATA  = 2'd1,
        IMM_DATA = 2'd2,
        ISSUE    = 2'd3
    } state_t;
`endif

    // ALU-immediate (0xC_) and branch/jump (0xD_) opcodes carry a second byte.
    function automatic logic is_two_byte(input logic [7:0] op);
        is_two_byte = (op[7:4] == 4'hC) || (op[7:4] == 4'hD);
    endfunction

`ifdef FETCH_HALT_EN
    // Opcode that stops fetch once execute has accepted it.
    function automatic logic is_halt_op(input logic [7:0] op);
        is_halt_op = (op == 8'hFF);
    endfunction
`endif

    state_t     state_r;
    state_t     state_next_s;

    logic       instr_valid_r;
    logic [7:0] opcode_r;
    logic [7:0] operand_r;
    logic [7:0] instr_pc_r;

    logic       pc_load_s;
    logic       pc_inc_s;
    logic [7:0] pc_load_value_s;
    logic       rd_en_s;
    logic [7:0] rd_addr_s;
    logic       redirect_take_s;
    logic       lat_pc_s;
    logic       lat_op_s;
    logic       lat_imm_s;
    logic       clr_imm_s;

    // A redirect is honoured in every state except HALT.
`ifdef FETCH_HALT_EN
    assign redirect_take_s = redirect && (state_r != HALT);
`else
    assign redirect_take_s = redirect;
`endif

    // Next-state decode plus the combinational PC / memory controls.
    always_comb begin
        state_next_s    = state_r;
        pc_load_s       = 1'b0;
        pc_inc_s        = 1'b0;
        pc_load_value_s = 8'h00;
        rd_en_s         = 1'b0;
        rd_addr_s       = 8'h00;
        lat_pc_s        = 1'b0;
        lat_op_s        = 1'b0;
        lat_imm_s       = 1'b0;
        clr_imm_s       = 1'b0;

        if (redirect_take_s) begin
            // Branch wins over everything, including a coincident handshake;
            // any byte still coming back from memory is simply not latched.
            pc_load_s       = 1'b1;
            pc_load_value_s = redirect_target;
            state_next_s    = FETCH_OP;
        end else begin
            case (state_r)
                FETCH_OP: begin
                    rd_en_s      = 1'b1;
                    rd_addr_s    = pc_value;
                    pc_inc_s     = 1'b1;
                    lat_pc_s     = 1'b1;
                    state_next_s = OP_DATA;
                end
                OP_DATA: begin
                    lat_op_s = 1'b1;
                    if (is_two_byte(mem_rd_data)) begin
                        // Operand read overlaps the opcode capture; the PC
                        // block handles the 0xFF -> 0x00 wrap.
                        rd_en_s      = 1'b1;
                        rd_addr_s    = pc_value;
                        pc_inc_s     = 1'b1;
                        state_next_s = IMM_DATA;
                    end else begin
                        clr_imm_s    = 1'b1;
                        state_next_s = ISSUE;
                    end
                end
                IMM_DATA: begin
                    lat_imm_s    = 1'b1;
                    state_next_s = ISSUE;
                end
                ISSUE: begin
                    if (instr_ready) begin
`ifdef FETCH_HALT_EN
                        if (is_halt_op(opcode_r)) begin
                            state_next_s = HALT;
                        end else begin
                            state_next_s = FETCH_OP;
                        end
`else
                        state_next_s = FETCH_OP;
`endif
                    end else begin
                        state_next_s = ISSUE;
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    state_next_s = HALT;
                end
`endif
                default: begin
                    state_next_s = FETCH_OP;
                end
            endcase
        end
    end

    // State register; instr_valid is registered and tracks the ISSUE state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= FETCH_OP;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            instr_valid_r <= (state_next_s == ISSUE);
        end
    end

    // Instruction assembly registers; held stable while waiting in ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_pc_r <= 8'h00;
            opcode_r   <= 8'h00;
            operand_r  <= 8'h00;
        end else begin
            if (lat_pc_s) begin
                instr_pc_r <= pc_value;
            end
            if (lat_op_s) begin
                opcode_r <= mem_rd_data;
            end
            if (lat_imm_s) begin
                operand_r <= mem_rd_data;
            end else if (clr_imm_s) begin
                operand_r <= 8'h00;
            end
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_r;

    // HALT is absorbing, so halted simply mirrors entry into that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= (state_next_s == HALT);
        end
    end

    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    assign pc_load       = pc_load_s;
    assign pc_inc        = pc_inc_s;
    assign pc_load_value = pc_load_value_s;
    assign mem_rd_en     = rd_en_s;
    assign mem_rd_addr   = rd_addr_s;
    assign instr_valid   = instr_valid_r;
    assign instr_opcode  = opcode_r;
    assign instr_operand = operand_r;
    assign instr_pc      = instr_pc_r;

endmodule
